avmm_burst_ram_slave: RTL and testbench
=======================================

// Module: avmm_burst_ram_slave
// PURPOSE
//  Avalon-MM burst-capable RAM slave; the downstream target the system's mm_master BFM drives in simulation.
//  Accepts incrementing write/read bursts with byteenables, waitrequest and pipelined readdatavalid.
//  Fixed read latency; optional random waitrequest insertion to stress master backpressure handling.
// PARAMETERS
//  ADDR_W        32    byte address width (word index = avs_address[2 +: log2(MEM_WORDS)])
//  DATA_W        32    data width; byteenable width = DATA_W/8
//  BURST_W       8     burstcount width
//  MEM_WORDS     1024  memory depth in words (power of 2)
//  READ_LATENCY  2     cycles from read issue to readdatavalid, legal 1..8
// PORTS
//  clk                input   1          clock
//  reset              input   1          synchronous active-high reset
//  avs_address        input   ADDR_W     byte address, sampled on command beat only
//  avs_burstcount     input   BURST_W    burst length, sampled on command beat only
//  avs_write          input   1          write request
//  avs_writedata      input   DATA_W     write data
//  avs_byteenable     input   DATA_W/8   byte lane enables for writes
//  avs_read           input   1          read request
//  avs_waitrequest    output  1          stall; beat/command accepted when request & !waitrequest
//  avs_readdata       output  DATA_W     read data, valid with readdatavalid
//  avs_readdatavalid  output  1          one pulse per returned read beat
//  protocol_err       output  1          sticky flag, cleared only by reset
// BEHAVIOUR
//  Reset (sync, active-high): waitrequest=1, readdatavalid=0, readdata=0, protocol_err=0; FSM->IDLE;
//   read pipeline flushed, in-flight beats dropped; memory contents NOT cleared. Reset mid-burst aborts it.
//  FSM states IDLE, WR_BURST, RD_ISSUE:
//   IDLE: waitrequest=0. write accepted -> writes beat 0 at base word; if burstcount>1 -> WR_BURST, remaining=bc-1.
//    read accepted -> latch base, count=bc -> RD_ISSUE; beat 0 issued in the accept cycle.
//    read&write same cycle: write accepted, read ignored, protocol_err<=1.
//    burstcount==0: treated as 1, protocol_err<=1.
//   WR_BURST: waitrequest=0; each cycle with avs_write writes beat i at base+i (byteenable-masked);
//    write=0 cycles are idle gaps; address/burstcount ignored; avs_read here -> protocol_err<=1, not accepted.
//    last beat -> IDLE next cycle.
//   RD_ISSUE: waitrequest=1; issues one word per cycle, consecutive; after last issue -> IDLE.
//    New command accepted in IDLE while earlier read beats still drain (pipelined, unlimited pending).
//  Read timing: beat issued in cycle t -> readdatavalid/readdata in cycle t+READ_LATENCY; N-beat burst returns
//   N valid beats on N consecutive cycles, order preserved.
//  Read-after-write: a read issued the cycle after a write beat returns the new data (no bypass needed, write commits on accept edge).
//  Addressing: word index = (base + i) mod MEM_WORDS; wraps silently, no error. avs_address[1:0] ignored.
//  Width rules: beat counter BURST_W bits; index arithmetic in log2(MEM_WORDS) bits, truncating.
// CONFIGURATION
//  AVMM_SLAVE_RAND_WAIT_EN defined: 16-bit LFSR (seed 16'hACE1, reset value) inserts extra waitrequest=1
//   in IDLE and WR_BURST when lfsr[1:0]==2'b00 (~25%); no beat/command accepted in a stalled cycle;
//   read-issue timing in RD_ISSUE unchanged. LFSR advances every cycle.
//  Undefined: waitrequest exactly as above (0 in IDLE/WR_BURST, 1 in RD_ISSUE and reset); no LFSR logic.
// STRUCTURE
//  Package avmm_pkg: state enum avmm_slv_state_t {IDLE, WR_BURST, RD_ISSUE}, LFSR seed/taps constants,
//   byteenable width function.
//  Sub-module avmm_ram_core: single-port-read/single-port-write byte-enabled RAM with registered output
//   (1 cycle); remaining READ_LATENCY-1 stages are a valid/data shift register in this module.
// TESTING
//  1 single write 0x10 data 0xDEADBEEF be 4'hF, then read bc=1 -> readdatavalid exactly 2 cycles after accept, data 0xDEADBEEF.
//  2 write burst bc=4 at 0x100 data 1..4, read bc=4 -> 4 consecutive valid beats 1,2,3,4; waitrequest high 3 cycles after accept.
//  3 write 0xFFFFFFFF then be=4'b0101 data 0x00000000 -> read returns 0xFF00FF00.
//  4 write burst bc=3 starting at last word (MEM_WORDS-1) -> words MEM_WORDS-1, 0, 1 written; read back matches.
//  5 read&write same cycle, and write bc=0 -> write performed, protocol_err=1 held until reset.
//  6 reset asserted mid read burst bc=8 -> no readdatavalid after reset edge; waitrequest=1 during reset, 0 one cycle after release.

Source files
------------

// File: rtl/avmm_pkg.sv
// rtl/avmm_pkg.sv - shared types, constants and helpers for the Avalon-MM burst RAM slave
// Contents: avmm_slv_state_t (IDLE, WR_BURST, RD_ISSUE), LFSR seed/taps, be_width().
package avmm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_ISSUE = 2'd2
    } avmm_slv_state_t;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/avmm_burst_ram_slave_if.sv
// rtl/avmm_burst_ram_slave_if.sv - Avalon-MM burst bus interface with master/slave modports
// Signals: avs_address, avs_burstcount, avs_write, avs_writedata, avs_byteenable, avs_read (master -> slave);
//          avs_waitrequest, avs_readdata, avs_readdatavalid (slave -> master).
interface avmm_burst_ram_slave_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 8
);
    import avmm_pkg::*;

    localparam int BE_W = be_width(DATA_W);

    logic [ADDR_W-1:0]  avs_address;
    logic [BURST_W-1:0] avs_burstcount;
    logic               avs_write;
    logic [DATA_W-1:0]  avs_writedata;
    logic [BE_W-1:0]    avs_byteenable;
    logic               avs_read;
    logic               avs_waitrequest;
    logic [DATA_W-1:0]  avs_readdata;
    logic               avs_readdatavalid;

    modport master (
        output avs_address, avs_burstcount, avs_write, avs_writedata, avs_byteenable, avs_read,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_burstcount, avs_write, avs_writedata, avs_byteenable, avs_read,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );

endinterface

// File: rtl/avmm_ram_core.sv
// rtl/avmm_ram_core.sv - byte-enabled word RAM with fixed-latency valid/data read pipeline
// Ports: clk, reset (sync, active-high), wr_en/wr_idx/wr_data/wr_be (write port),
//        rd_en/rd_idx (read issue), rd_valid/rd_data (read return READ_LATENCY cycles after issue).
module avmm_ram_core
    import avmm_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 2,
    localparam int IDX_W       = $clog2(MEM_WORDS),
    localparam int BE_W        = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    // Memory contents survive reset on purpose.
    logic [DATA_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 is the RAM output register; stages 1..READ_LATENCY-1 pad to the fixed latency.
    logic [READ_LATENCY-1:0] vld_sr;
    logic [DATA_W-1:0]       dat_sr [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= rd_en;
            if (rd_en) begin
                dat_sr[0] <= mem[rd_idx];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                dat_sr[i] <= dat_sr[i-1];
            end
        end
    end

    assign rd_valid = vld_sr[READ_LATENCY-1];
    assign rd_data  = dat_sr[READ_LATENCY-1];

endmodule

// File: rtl/avmm_burst_ram_slave.sv
// rtl/avmm_burst_ram_slave.sv - Avalon-MM burst-capable RAM slave with pipelined fixed-latency reads
// Ports: clk, reset (sync, active-high), avs (avmm_burst_ram_slave_if.slave), protocol_err (sticky).
// Build option: AVMM_SLAVE_RAND_WAIT_EN adds LFSR-driven extra waitrequest in IDLE/WR_BURST.
module avmm_burst_ram_slave
    import avmm_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BURST_W      = 8,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    avmm_burst_ram_slave_if.slave avs,
    output logic                  protocol_err
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    avmm_slv_state_t    state, state_nxt;
    logic [IDX_W-1:0]   base_idx, base_nxt;
    logic [IDX_W-1:0]   offset, offset_nxt;
    logic [BURST_W-1:0] remaining, remaining_nxt;

    logic               waitreq;
    logic               err_set;
    logic               wr_en, rd_en;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               stall;

    logic [IDX_W-1:0]   cmd_idx;
    logic               bc_zero;
    logic [BURST_W-1:0] cmd_bc;
    logic               unused_addr;

    assign cmd_idx     = avs.avs_address[2 +: IDX_W];
    assign bc_zero     = (avs.avs_burstcount == '0);
    assign cmd_bc      = bc_zero ? BURST_W'(1) : avs.avs_burstcount;
    assign unused_addr = ^avs.avs_address;

`ifdef AVMM_SLAVE_RAND_WAIT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            base_idx     <= '0;
            offset       <= '0;
            remaining    <= '0;
            protocol_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            base_idx  <= base_nxt;
            offset    <= offset_nxt;
            remaining <= remaining_nxt;
            if (err_set) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // While reset is high nothing is accepted and waitrequest stays asserted.
    always_comb begin
        state_nxt     = state;
        base_nxt      = base_idx;
        offset_nxt    = offset;
        remaining_nxt = remaining;
        waitreq       = 1'b1;
        err_set       = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = cmd_idx;
        rd_en         = 1'b0;
        rd_idx        = cmd_idx;

        if (!reset) begin
            unique case (state)
                IDLE: begin
                    waitreq = stall;
                    if (!stall) begin
                        if (avs.avs_write) begin
                            // A simultaneous read is dropped and flagged.
                            wr_en   = 1'b1;
                            wr_idx  = cmd_idx;
                            err_set = avs.avs_read || bc_zero;
                            if (cmd_bc > BURST_W'(1)) begin
                                state_nxt     = WR_BURST;
                                base_nxt      = cmd_idx;
                                offset_nxt    = IDX_W'(1);
                                remaining_nxt = cmd_bc - BURST_W'(1);
                            end
                        end else if (avs.avs_read) begin
                            rd_en   = 1'b1;
                            rd_idx  = cmd_idx;
                            err_set = bc_zero;
                            if (cmd_bc > BURST_W'(1)) begin
                                state_nxt     = RD_ISSUE;
                                base_nxt      = cmd_idx;
                                offset_nxt    = IDX_W'(1);
                                remaining_nxt = cmd_bc - BURST_W'(1);
                            end
                        end
                    end
                end

                WR_BURST: begin
                    waitreq = stall;
                    if (!stall) begin
                        if (avs.avs_read) begin
                            err_set = 1'b1;
                        end
                        if (avs.avs_write) begin
                            wr_en         = 1'b1;
                            wr_idx        = base_idx + offset;
                            offset_nxt    = offset + IDX_W'(1);
                            remaining_nxt = remaining - BURST_W'(1);
                            if (remaining == BURST_W'(1)) begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                end

                RD_ISSUE: begin
                    waitreq       = 1'b1;
                    rd_en         = 1'b1;
                    rd_idx        = base_idx + offset;
                    offset_nxt    = offset + IDX_W'(1);
                    remaining_nxt = remaining - BURST_W'(1);
                    if (remaining == BURST_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    avmm_ram_core #(
        .DATA_W       (DATA_W),
        .MEM_WORDS    (MEM_WORDS),
        .READ_LATENCY (READ_LATENCY)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (avs.avs_writedata),
        .wr_be    (avs.avs_byteenable),
        .rd_en    (rd_en),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    assign avs.avs_waitrequest   = waitreq;
    assign avs.avs_readdatavalid = rd_valid;
    assign avs.avs_readdata      = rd_data;

endmodule

// File: tb/tb_avmm_burst_ram_slave.sv
// tb/tb_avmm_burst_ram_slave.sv - directed self-checking bench for avmm_burst_ram_slave
module tb_avmm_burst_ram_slave;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic perr;

    always #5 clk = ~clk;

    avmm_burst_ram_slave_if #(.ADDR_W(32), .DATA_W(32), .BURST_W(8)) bus ();

    avmm_burst_ram_slave #(
        .ADDR_W(32), .DATA_W(32), .BURST_W(8), .MEM_WORDS(1024), .READ_LATENCY(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .avs          (bus),
        .protocol_err (perr)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] rv_q [$];
    int          rv_cyc [$];

    always @(negedge clk) begin
        if (bus.avs_readdatavalid === 1'b1) begin
            rv_q.push_back(bus.avs_readdata);
            rv_cyc.push_back(cyc);
        end
    end

    task automatic idle_bus();
        bus.avs_write      = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_address    = '0;
        bus.avs_burstcount = 8'd1;
        bus.avs_writedata  = '0;
        bus.avs_byteenable = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rv();
        rv_q.delete();
        rv_cyc.delete();
    endtask

    // Holds the current request until the negedge where waitrequest is low; returns that cycle.
    task automatic wait_accept(output int acc);
        int n = 0;
        @(negedge clk);
        while (bus.avs_waitrequest !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: waitrequest=%b after %0d cycles, required 0", bus.avs_waitrequest, n);
        end
        acc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [7:0] bc,
                            input logic [31:0] d0, input logic [3:0] be);
        int beats;
        int acc;
        beats = (bc == 8'd0) ? 1 : int'(bc);
        for (int i = 0; i < beats; i++) begin
            bus.avs_write      = 1'b1;
            bus.avs_address    = addr;
            bus.avs_burstcount = bc;
            bus.avs_writedata  = d0 + i;
            bus.avs_byteenable = be;
            wait_accept(acc);
        end
        bus.avs_write = 1'b0;
    endtask

    task automatic rd_cmd(input logic [31:0] addr, input logic [7:0] bc, output int acc);
        bus.avs_read       = 1'b1;
        bus.avs_address    = addr;
        bus.avs_burstcount = bc;
        wait_accept(acc);
        bus.avs_read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.avs_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitrequest: got %b want 1", bus.avs_waitrequest); end
        checks++; if (bus.avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_readdatavalid: got %b want 0", bus.avs_readdatavalid); end
        checks++; if (bus.avs_readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h want 00000000", bus.avs_readdata); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL rst_protocol_err: got %b want 0", perr); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.avs_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_release_wait: got %b want 0", bus.avs_waitrequest); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int acc;
        wr_burst(32'h10, 8'd1, 32'hDEADBEEF, 4'hF);
        clear_rv();
        rd_cmd(32'h10, 8'd1, acc);
        tick(6);
        checks++; if (rv_q.size() !== 1) begin errors++; $display("FAIL single_beats: got %0d want 1", rv_q.size()); end
        if (rv_q.size() >= 1) begin
            checks++; if (rv_q[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", rv_q[0]); end
            checks++; if (rv_cyc[0] - acc !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", rv_cyc[0] - acc); end
        end
    endtask

    task automatic test_burst();
        int acc;
        int hi;
        logic w;
        wr_burst(32'h100, 8'd4, 32'd1, 4'hF);
        clear_rv();
        rd_cmd(32'h100, 8'd4, acc);
        hi = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.avs_waitrequest === 1'b1) hi++;
        end
        @(negedge clk);
        w = bus.avs_waitrequest;
        checks++; if (hi !== 3) begin errors++; $display("FAIL burst_wait_high: got %0d cycles want 3", hi); end
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL burst_wait_release: got %b want 0", w); end
        tick(6);
        checks++; if (rv_q.size() !== 4) begin errors++; $display("FAIL burst_beats: got %0d want 4", rv_q.size()); end
        for (int i = 0; i < 4 && i < rv_q.size(); i++) begin
            checks++; if (rv_q[i] !== 32'(i + 1)) begin errors++; $display("FAIL burst_data[%0d]: got %h want %h", i, rv_q[i], 32'(i + 1)); end
            checks++; if (rv_cyc[i] !== acc + 2 + i) begin errors++; $display("FAIL burst_cycle[%0d]: got %0d want %0d", i, rv_cyc[i], acc + 2 + i); end
        end
    endtask

    task automatic test_byteenable();
        int acc;
        wr_burst(32'h20, 8'd1, 32'hFFFFFFFF, 4'hF);
        wr_burst(32'h20, 8'd1, 32'h00000000, 4'b0101);
        clear_rv();
        rd_cmd(32'h20, 8'd1, acc);
        tick(6);
        checks++; if (rv_q.size() !== 1) begin errors++; $display("FAIL be_beats: got %0d want 1", rv_q.size()); end
        if (rv_q.size() >= 1) begin
            checks++; if (rv_q[0] !== 32'hFF00FF00) begin errors++; $display("FAIL be_data: got %h want ff00ff00", rv_q[0]); end
        end
    endtask

    task automatic test_wrap();
        int acc;
        wr_burst(32'hFFC, 8'd3, 32'hA0, 4'hF);
        clear_rv();
        rd_cmd(32'hFFC, 8'd3, acc);
        tick(8);
        checks++; if (rv_q.size() !== 3) begin errors++; $display("FAIL wrap_beats: got %0d want 3", rv_q.size()); end
        for (int i = 0; i < 3 && i < rv_q.size(); i++) begin
            checks++; if (rv_q[i] !== 32'(32'hA0 + i)) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, rv_q[i], 32'(32'hA0 + i)); end
        end
        clear_rv();
        rd_cmd(32'h1004, 8'd1, acc);
        tick(6);
        checks++; if (rv_q.size() !== 1) begin errors++; $display("FAIL alias_beats: got %0d want 1", rv_q.size()); end
        if (rv_q.size() >= 1) begin
            checks++; if (rv_q[0] !== 32'hA2) begin errors++; $display("FAIL alias_data: got %h want 000000a2", rv_q[0]); end
        end
    endtask

    task automatic test_protocol();
        int acc;
        @(negedge clk);
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL perr_initial: got %b want 0", perr); end
        @(posedge clk);
        #1;
        clear_rv();
        bus.avs_read = 1'b1;
        wr_burst(32'h40, 8'd1, 32'h12345678, 4'hF);
        bus.avs_read = 1'b0;
        @(negedge clk);
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL perr_rw_same: got %b want 1", perr); end
        tick(4);
        checks++; if (rv_q.size() !== 0) begin errors++; $display("FAIL perr_read_ignored: got %0d beats want 0", rv_q.size()); end
        rd_cmd(32'h40, 8'd1, acc);
        tick(6);
        checks++; if (rv_q.size() !== 1) begin errors++; $display("FAIL perr_rw_beats: got %0d want 1", rv_q.size()); end
        if (rv_q.size() >= 1) begin
            checks++; if (rv_q[0] !== 32'h12345678) begin errors++; $display("FAIL perr_rw_data: got %h want 12345678", rv_q[0]); end
        end
        @(negedge clk);
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b want 1", perr); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL perr_cleared: got %b want 0", perr); end
        @(posedge clk);
        #1;
        wr_burst(32'h44, 8'd0, 32'h55AA55AA, 4'hF);
        @(negedge clk);
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL perr_bc_zero: got %b want 1", perr); end
        checks++; if (bus.avs_waitrequest !== 1'b0) begin errors++; $display("FAIL bc_zero_idle: got %b want 0", bus.avs_waitrequest); end
        @(posedge clk);
        #1;
        clear_rv();
        rd_cmd(32'h44, 8'd1, acc);
        tick(6);
        checks++; if (rv_q.size() !== 1) begin errors++; $display("FAIL bc_zero_beats: got %0d want 1", rv_q.size()); end
        if (rv_q.size() >= 1) begin
            checks++; if (rv_q[0] !== 32'h55AA55AA) begin errors++; $display("FAIL bc_zero_data: got %h want 55aa55aa", rv_q[0]); end
        end
    endtask

    task automatic test_reset_mid_read();
        int acc;
        rd_cmd(32'h100, 8'd8, acc);
        reset = 1'b1;
        clear_rv();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.avs_waitrequest !== 1'b1) begin errors++; $display("FAIL midrst_wait[%0d]: got %b want 1", k, bus.avs_waitrequest); end
            checks++; if (bus.avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL midrst_valid[%0d]: got %b want 0", k, bus.avs_readdatavalid); end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.avs_waitrequest !== 1'b0) begin errors++; $display("FAIL midrst_release_wait: got %b want 0", bus.avs_waitrequest); end
        tick(12);
        checks++; if (rv_q.size() !== 0) begin errors++; $display("FAIL midrst_dropped: got %0d beats want 0", rv_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_byteenable();
        test_wrap();
        test_protocol();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
